// File: rtl/sm_pkg.sv
// Shared sign-magnitude definitions: widths, FSM state encoding, result payload
// and the sign-magnitude to two's-complement helper.
package sm_pkg;

    localparam int unsigned SM_W  = 16;
    localparam int unsigned MAG_W = SM_W - 1;
    localparam int unsigned LEN_W = 8;
    localparam int unsigned ACC_W = SM_W + LEN_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic            ovf;
        logic [SM_W-1:0] data;
    } sm_result_t;

    // Sign-magnitude word to ACC_W two's complement; negative zero maps to 0.
    function automatic logic [ACC_W-1:0] sm2tc(input logic [SM_W-1:0] x);
        logic [ACC_W-1:0] mag;
        mag = ACC_W'(x[MAG_W-1:0]);
        return x[SM_W-1] ? (ACC_W'(0) - mag) : mag;
    endfunction

endpackage

// File: rtl/sm_tc2sm_sat.sv
// Two's-complement to sign-magnitude conversion with saturation and overflow flag.
// Zero always comes out as +0 because a zero input has a clear sign bit.
module sm_tc2sm_sat
    import sm_pkg::*;
#(
    parameter int unsigned IN_W = ACC_W
) (
    input  logic [IN_W-1:0] acc,
    output sm_result_t      result_c
);

    logic            neg;
    logic [IN_W-1:0] mag;
    logic            ovf;

    // Magnitude, range check and clamp.
    always_comb begin
        neg           = acc[IN_W-1];
        mag           = neg ? (IN_W'(0) - acc) : acc;
        ovf           = |mag[IN_W-1:MAG_W];
        result_c.ovf  = ovf;
        result_c.data = {neg, (ovf ? {MAG_W{1'b1}} : mag[MAG_W-1:0])};
    end

endmodule

// File: rtl/sm_accumulator.sv
// Sign-magnitude stream accumulator: sums len products per job and emits one
// saturated sign-magnitude result with an overflow flag.
module sm_accumulator
    import sm_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SM_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SM_W-1:0]  out_data,
    output logic             out_ovf,
    output logic             busy
);

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;
    logic [LEN_W-1:0] count;
    logic [LEN_W-1:0] len_q;
    sm_result_t       sum_res;

    // Running sum including the term currently offered on in_data.
    always_comb begin
        acc_sum = acc + sm2tc(in_data);
    end

    // Result conversion of the sum as it stands after the final handshake.
    sm_tc2sm_sat #(
        .IN_W (ACC_W)
    ) u_sat (
        .acc      (acc_sum),
        .result_c (sum_res)
    );

    // Job control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            len_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= len;
                        acc   <= '0;
                        count <= '0;
                        busy  <= 1'b1;
                        if (len != '0) begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_ovf   <= 1'b0;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid && in_ready) begin
                        acc   <= acc_sum;
                        count <= count + LEN_W'(1);
                        if (count == len_q - LEN_W'(1)) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= sum_res.data;
                            out_ovf   <= sum_res.ovf;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_accumulator.sv
// Bench for sm_accumulator: table of jobs plus hand sequences for len=0,
// stalls/backpressure, the 255-term boundary and reset mid-job.
module tb_sm_accumulator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  len;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_ovf;
    logic        busy;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        ovf;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [7:0]       len;
        logic [3:0][15:0] t;
        logic [15:0]      data;
        logic             ovf;
    } vec_t;

    exp_t q[$];
    exp_t mon_e;
    vec_t vt[8];

    always #5 clk = ~clk;

    sm_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] l, input logic [15:0] t0, input logic [15:0] t1,
                                input logic [15:0] t2, input logic [15:0] t3,
                                input logic [15:0] d, input logic o);
        vec_t v;
        v.len  = l;
        v.t    = {t3, t2, t1, t0};
        v.data = d;
        v.ovf  = o;
        return v;
    endfunction

    // Scoreboard: every accepted result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got %0h expected no result", out_data);
            end else begin
                mon_e = q.pop_front();
                check("result_data", 32'(out_data), 32'(mon_e.data));
                check("result_ovf", 32'(out_ovf), 32'(mon_e.ovf));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic [7:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    // Offer one term until it is accepted; optionally idle one cycle afterwards.
    task automatic send(input logic [15:0] d, input bit gap);
        int n;
        bit done;
        n        = 0;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1");
                done = 1'b1;
            end
            n++;
            tick();
        end
        in_valid = 1'b0;
        in_data  = 16'h0;
        if (gap) tick();
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 400) begin
            tick();
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got 1 expected 0");
        end
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = 8'd0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;

        vt[0] = mk(8'd3, 16'd5,    16'd7,    16'h8002, 16'h0,    16'd10,   1'b0);
        vt[1] = mk(8'd2, 16'h4E20, 16'h4E20, 16'h0,    16'h0,    16'h7FFF, 1'b1);
        vt[2] = mk(8'd2, 16'hCE20, 16'hCE20, 16'h0,    16'h0,    16'hFFFF, 1'b1);
        vt[3] = mk(8'd3, 16'h7530, 16'h7530, 16'hF530, 16'h0,    16'h7530, 1'b0);
        vt[4] = mk(8'd2, 16'h8000, 16'h0000, 16'h0,    16'h0,    16'h0000, 1'b0);
        vt[5] = mk(8'd4, 16'd100,  16'h8032, 16'd7,    16'h8039, 16'h0000, 1'b0);
        vt[6] = mk(8'd1, 16'hFFFF, 16'h0,    16'h0,    16'h0,    16'hFFFF, 1'b0);
        vt[7] = mk(8'd2, 16'h7FFF, 16'h0001, 16'h0,    16'h0,    16'h7FFF, 1'b1);

        #12;
        check("reset_state", {27'h0, in_ready, out_valid, out_ovf, busy, |out_data}, 32'h0);
        tick();
        reset = 1'b0;
        tick();

        // Table-driven jobs, in_valid held high between terms.
        for (int i = 0; i < 8; i++) begin
            q.push_back({vt[i].ovf, vt[i].data});
            start_job(vt[i].len);
            for (int k = 0; k < int'(vt[i].len); k++) send(vt[i].t[k], 1'b0);
            @(negedge clk);
            check("latency_out_valid", 32'(out_valid), 32'h1);
            check("done_in_ready", 32'(in_ready), 32'h0);
            wait_idle();
        end

        // Zero-length job finishes without ever opening the input.
        q.push_back({1'b0, 16'h0});
        start_job(8'd0);
        @(negedge clk);
        check("len0_out_valid", 32'(out_valid), 32'h1);
        check("len0_in_ready", 32'(in_ready), 32'h0);
        wait_idle();

        // Stalled input, start pulses mid-job, and held result under backpressure.
        out_ready = 1'b0;
        q.push_back({1'b0, 16'd100});
        start_job(8'd4);
        send(16'd10, 1'b1);
        start = 1'b1;
        len   = 8'd1;
        send(16'h8003, 1'b1);
        start = 1'b0;
        send(16'd100, 1'b1);
        send(16'h8007, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) start = 1'b1;
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'h1);
            check("stall_out_data", 32'(out_data), 32'd100);
            tick();
            start = 1'b0;
        end
        out_ready = 1'b1;
        wait_idle();
        tick();
        tick();
        check("no_spurious_job", 32'(busy), 32'h0);

        // Longest job at full-scale magnitude must not wrap.
        q.push_back({1'b1, 16'h7FFF});
        start_job(8'd255);
        for (int k = 0; k < 255; k++) send(16'h7FFF, 1'b0);
        wait_idle();

        // Reset in the middle of a job drops it without a result.
        start_job(8'd4);
        send(16'd3, 1'b0);
        send(16'd4, 1'b0);
        in_valid = 1'b1;
        in_data  = 16'd5;
        #2;
        reset = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_ovf", 32'(out_ovf), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        tick();
        in_valid = 1'b0;
        in_data  = 16'h0;
        reset    = 1'b0;
        tick();
        q.push_back({1'b0, 16'h8009});
        start_job(8'd1);
        send(16'h8009, 1'b0);
        wait_idle();

        tick();
        tick();
        check("queue_drained", 32'(q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sm_accumulator.md
Name: sm_accumulator

Overview:
- Sequential reduction stage directly downstream of the 16-bit sign-magnitude multiplier.
- Consumes a stream of products (bit 15 = sign, bits 14:0 = magnitude) under a valid/ready handshake and sums a programmed number of terms.
- Emits one saturated sign-magnitude result per job, with an overflow flag.
- Used for dot products and polynomial evaluation, so the multiplier output can be reduced without software loops.

Parameters:
- SM_W, 16, total sign-magnitude word width (1 sign + SM_W-1 magnitude bits).
- LEN_W, 8, width of the term-count input; maximum job length is 2^LEN_W-1 terms.
- ACC_W, SM_W+LEN_W, internal two's-complement accumulator width. This width is large enough that the internal sum cannot overflow.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a job. Sampled only in IDLE.
- len  in  LEN_W  number of terms in the job. Latched on start.
- in_valid  in  1  upstream product valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  SM_W  sign-magnitude product.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts result.
- out_data  out  SM_W  saturated sign-magnitude sum.
- out_ovf  out  1  |sum| exceeded 2^(SM_W-1)-1. Valid with out_valid.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces all outputs and state to known values:
  - state = IDLE, acc = 0, count = 0.
  - in_ready = 0, out_valid = 0, out_data = 0, out_ovf = 0, busy = 0.
- The FSM has three states: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready = 0.
  - start = 1 latches len, clears acc and count.
  - If len != 0, go to ACCUM. If len = 0, go to DONE with a result of 0 and ovf = 0.
  - start is ignored in every state other than IDLE.
- ACCUM:
  - in_ready = 1 (registered; asserted on the first cycle in ACCUM).
  - A handshake occurs when in_valid & in_ready.
  - On each handshake: acc <= acc + sm2tc(in_data) and count <= count + 1.
  - On the handshake where count == len_q-1, go to DONE.
  - Cycles with in_valid = 0 are stalls: no change to acc or count.
- DONE:
  - out_valid = 1 starting the cycle after the final handshake, which gives a latency of 1 clock.
  - out_data and out_ovf are registered and held stable while out_valid & !out_ready.
  - On out_valid & out_ready, go to IDLE and clear out_valid. The same cycle in_ready is 0, so start is accepted no earlier than the following cycle.
- Arithmetic:
  - sm2tc(x) = x[SM_W-1] ? -x[SM_W-2:0] : x[SM_W-2:0], sign-extended to ACC_W.
  - Input negative zero (sign 1, magnitude 0) contributes 0.
  - Output conversion: magnitude = |acc|.
    - If magnitude > 2^(SM_W-1)-1, out_data = {sign(acc), all-ones magnitude} and out_ovf = 1.
    - Otherwise out_data = {sign, magnitude} and out_ovf = 0.
  - A zero result is always emitted as +0 (sign bit 0), never as -0.
  - Saturation applies only to the final sum. Intermediate sums may exceed the output range and later return into it, in which case ovf = 0.
- Boundaries:
  - len = 2^LEN_W-1 with every term at maximum magnitude must not wrap acc.
  - Reset asserted mid-job abandons the job immediately. No partial result is emitted.

Decomposition:
- Shared package sm_pkg holds:
  - constants SM_W = 16 and MAG_W = 15;
  - the FSM state typedef (IDLE/ACCUM/DONE);
  - function sm2tc.
- One combinational sub-module, sm_tc2sm_sat, performs the ACC_W two's-complement to SM_W sign-magnitude conversion with saturation and the ovf flag.
- The multiplier bench and a future divider reuse both sm_pkg and sm_tc2sm_sat.

Test Plan:
- len = 3, terms 0:5, 0:7, 1:2, in_valid held high → out_valid asserted 1 cycle after the 3rd handshake; out_data = 0:10, out_ovf = 0.
- len = 2, terms 0:20000, 0:20000 → out_data = 0:32767, out_ovf = 1. Repeat with 1:20000, 1:20000 → 1:32767, out_ovf = 1.
- len = 3, terms 0:30000, 0:30000, 1:30000 → out_data = 0:30000, out_ovf = 0 (intermediate excursion does not saturate). len = 2, terms 1:0, 0:0 → out_data = 0:0 (no negative zero).
- len = 0 start → DONE next cycle, out_data = 0, no in_ready asserted. Then len = 4 with in_valid toggling every other cycle and out_ready held low 5 cycles → sum correct, out_data stable while stalled, start pulses during ACCUM/DONE ignored.
- len = 255, all terms 0:32767 → out_data = 0:32767, out_ovf = 1, no wrap.
- Reset asserted after 2 of 4 handshakes → all outputs 0 immediately. Then a new job len = 1, term 1:9 → out_data = 1:9.
